clkout_div_ctrl: RTL and testbench
==================================

// Module: clkout_div_ctrl
// PURPOSE
//  Sequences the clkin->clkout path: generates a glitch-free, programmable-ratio divided clkout
//  from clkin. Provides run/stop control with clean period-boundary starts and stops, and
//  handshaked ratio reconfiguration. Sits between the board clock input and downstream
//  clock consumers; clkout is always a flop output, never combinational from clkin.
// PARAMETERS
//  CNT_W        8   width of divide ratio and period counter
//  DEFAULT_DIV  4   divide ratio loaded at reset (must be >= 2)
// PORTS
//  clkin        in   1      sole clock; all logic on posedge
//  rst          in   1      asynchronous, active-high reset
//  run_req      in   1      level: 1 = produce clkout, 0 = stop at next period end
//  cfg_valid    in   1      new ratio offered on cfg_div
//  cfg_div      in   CNT_W  requested ratio (clkin cycles per clkout period)
//  cfg_ready    out  1      1-cycle pulse: cfg_div accepted this cycle
//  clkout       out  1      divided clock (registered)
//  clkout_tick  out  1      1-cycle pulse in the clkin cycle where clkout rises
//  running      out  1      high in RUN and STOPPING
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, div=DEFAULT_DIV, clkout=0, clkout_tick=0, cfg_ready=0, running=0.
//  - Period: cnt counts 0..div-1; clkout=1 for cnt < hi_len, else 0; hi_len = div - (div>>1)
//    (ceil half; odd ratios are high-biased). clkout_tick=1 when cnt==0 in RUN.
//  - Ratio: cfg_div<2 clamps to 2. Accept = cfg_valid && (state==IDLE || cnt==div-1).
//    On accept: cfg_ready=1 that cycle; new div takes effect from the next cnt==0.
//    Otherwise the offer stays pending; the requester holds cfg_valid/cfg_div until cfg_ready.
//  - FSM IDLE: clkout=0, cnt=0; run_req=1 -> RUN, first cycle in RUN has cnt=0 (clkout rises,
//    tick=1). Latency run_req->clkout high: 1 clkin cycle.
//  - FSM RUN: run_req=0 -> STOPPING (current period continues).
//  - FSM STOPPING: at cnt==div-1: run_req=1 -> RUN (no gap, cnt wraps to 0);
//    else -> IDLE. Stop never truncates a high or low phase.
//  - Simultaneous cfg accept and stop at the same boundary: both take effect; new div is used
//    on the next start.
//  - Glitch-free: clkout changes only at cnt==0 and cnt==hi_len.
//  - Async rst mid-period: immediate clkout=0 (a truncated pulse is acceptable only under reset).
// CONFIGURATION
//  CLKOUT_DIV_CTRL_BURST_EN defined: adds ports burst_len (in, CNT_W) and burst_done (out,
//   1-cycle pulse). A rising edge of run_req latches burst_len; when burst_len!=0 exactly
//   burst_len full periods are emitted, then FSM -> IDLE and burst_done=1, even if run_req
//   stays high (restart needs run_req 0->1). burst_len=0 means unlimited.
//  Not defined: ports absent; run_req alone controls run/stop.
// STRUCTURE
//  - Package clkout_div_pkg: state_e {IDLE, RUN, STOPPING}, MIN_DIV=2, function hi_len(div).
//  - Sub-module clkout_phase_ctr: period counter, wrap flag (cnt==div-1), clkout/tick compare.
//    The top holds the FSM, cfg handshake and optional burst counter.
// TESTING
//  1 Reset, run_req=1, DEFAULT_DIV=4: clkout 1100 repeating; tick every 4th cycle; running=1.
//  2 cfg_div=5 mid-period: cfg_ready only at cnt==3; next period 11100 (hi=3, lo=2).
//  3 cfg_div=0 and 1: clamped, clkout toggles every cycle (div=2).
//  4 run_req=0 at cnt=1 (div=4): finish 1100, then clkout held 0, running=0 one cycle later;
//    re-raise run_req during STOPPING: continuous clkout, no extra low cycle.
//  5 rst asserted while clkout=1: clkout=0 asynchronously; all outputs at reset values.
//  6 BURST_EN, burst_len=3, div=2: exactly 3 ticks, burst_done once, clkout then 0 with
//    run_req still 1.

Source files
------------

// File: rtl/clkout_div_pkg.sv
// clkout_div_pkg: shared FSM states, ratio floor and high-phase helper for the clkout divider
package clkout_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;
  localparam int unsigned MIN_DIV = 2;
  function automatic int unsigned hi_len(input int unsigned div);
    return div - (div >> 1);
  endfunction
endpackage

// File: rtl/clkout_phase_ctr.sv
// clkout_phase_ctr: period counter with wrap flag and registered clkout/tick decode
module clkout_phase_ctr
  import clkout_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             hold,
  input  logic             active_nxt,
  input  logic             run_nxt,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] div_nxt,
  output logic             wrap,
  output logic             clkout,
  output logic             clkout_tick
);
  logic [CNT_W-1:0] cnt, cnt_nxt, hi_nxt;
  assign wrap = cnt == div - CNT_W'(1);
  assign cnt_nxt = (hold || wrap) ? '0 : cnt + CNT_W'(1);
  assign hi_nxt = CNT_W'(hi_len(32'(div_nxt)));
  // clkout and tick are decoded from next-cycle values so both leave a flop directly
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      clkout <= 1'b0;
      clkout_tick <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      clkout <= active_nxt && (cnt_nxt < hi_nxt);
      clkout_tick <= run_nxt && (cnt_nxt == '0);
    end
  end
endmodule

// File: rtl/clkout_div_ctrl.sv
// clkout_div_ctrl: run/stop FSM and ratio handshake for a glitch-free divided clkout (optional CLKOUT_DIV_CTRL_BURST_EN)
module clkout_div_ctrl
  import clkout_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             run_req,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clkout,
  output logic             clkout_tick,
  output logic             running
`ifdef CLKOUT_DIV_CTRL_BURST_EN
  ,
  input  logic [CNT_W-1:0] burst_len,
  output logic             burst_done
`endif
);
  state_e state, state_nxt;
  logic [CNT_W-1:0] div, div_nxt;
  logic wrap, run_eff, accept;
  assign accept = cfg_valid && !rst && (state == IDLE || wrap);
  assign cfg_ready = accept;
  assign div_nxt = !accept ? div : (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;
  assign running = state != IDLE;
`ifdef CLKOUT_DIV_CTRL_BURST_EN
  logic run_q, blocked, rise, done;
  logic [CNT_W-1:0] blen, bcnt;
  assign rise = run_req && !run_q;
  assign done = (state != IDLE) && wrap && !rise && (blen != '0) && (bcnt == blen - CNT_W'(1));
  assign run_eff = run_req && !blocked && !done;
  // burst bookkeeping: latch length on run_req rise, count completed periods, block until run_req drops
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      blocked <= 1'b0;
      blen <= '0;
      bcnt <= '0;
      burst_done <= 1'b0;
    end else begin
      run_q <= run_req;
      blocked <= run_req && (blocked || done);
      blen <= rise ? burst_len : blen;
      bcnt <= rise ? '0 : ((state != IDLE) && wrap) ? bcnt + CNT_W'(1) : bcnt;
      burst_done <= done;
    end
  end
`else
  assign run_eff = run_req;
`endif
  // state, ratio register
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      div <= CNT_W'(DEFAULT_DIV);
    end else begin
      state <= state_nxt;
      div <= div_nxt;
    end
  end
  // next state: starts from IDLE at once, otherwise decisions only at the period boundary
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (run_eff ? RUN : IDLE)
              : wrap ? (run_eff ? RUN : IDLE)
              : (state == RUN && !run_eff) ? STOPPING : state;
  end
  clkout_phase_ctr #(.CNT_W(CNT_W)) u_phase (
    .clkin(clkin),
    .rst(rst),
    .hold(state == IDLE),
    .active_nxt(state_nxt != IDLE),
    .run_nxt(state_nxt == RUN),
    .div(div),
    .div_nxt(div_nxt),
    .wrap(wrap),
    .clkout(clkout),
    .clkout_tick(clkout_tick)
  );
endmodule

// File: tb/tb_clkout_div_ctrl.sv
// tb_clkout_div_ctrl: directed plus random stimulus against a period-queue reference model
module tb_clkout_div_ctrl;
  localparam int CNT_W = 8;
  logic clkin = 1'b0, rst = 1'b1, run_req = 1'b0, cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic cfg_ready, clkout, clkout_tick, running;
  int ncmp = 0, nfail = 0;
  int m_div = 4;
  bit q[$];
  bit fresh = 1'b0;
  logic last_ready = 1'b0;
`ifdef CLKOUT_DIV_CTRL_BURST_EN
  logic [CNT_W-1:0] burst_len = '0;
  logic burst_done;
  bit b_prev = 0, b_block = 0, b_done = 0;
  int b_len = 0, b_n = 0;
`endif
  always #5 clkin = ~clkin;
  clkout_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clkin(clkin),
    .rst(rst),
    .run_req(run_req),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .clkout(clkout),
    .clkout_tick(clkout_tick),
    .running(running)
`ifdef CLKOUT_DIV_CTRL_BURST_EN
    ,
    .burst_len(burst_len),
    .burst_done(burst_done)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_div = 4;
    fresh = 0;
`ifdef CLKOUT_DIV_CTRL_BURST_EN
    b_prev = 0; b_block = 0; b_done = 0; b_len = 0; b_n = 0;
`endif
  endtask
  // one clkin edge of the reference: a whole period pattern is queued when a period starts
  task automatic model_edge();
    bit go;
`ifdef CLKOUT_DIV_CTRL_BURST_EN
    bit rise;
`endif
    if (cfg_valid && q.size() <= 1) m_div = (cfg_div < 2) ? 2 : int'(cfg_div);
    go = run_req;
`ifdef CLKOUT_DIV_CTRL_BURST_EN
    rise = run_req && !b_prev;
    if (rise) begin b_len = int'(burst_len); b_n = 0; end
    else if (q.size() == 1) b_n++;
    b_done = !rise && q.size() == 1 && b_len != 0 && b_n == b_len;
    go = run_req && !b_block && !b_done;
    b_block = run_req && (b_block || b_done);
    b_prev = run_req;
`endif
    fresh = 0;
    if (q.size() > 1) void'(q.pop_front());
    else begin
      q.delete();
      if (go) begin
        for (int i = 0; i < m_div; i++) q.push_back(i < m_div - m_div / 2);
        fresh = 1;
      end
    end
  endtask
  task automatic step();
    @(negedge clkin);
    last_ready = cfg_ready;
    chk("clkout", 32'(clkout), 32'(q.size() != 0 ? q[0] : 1'b0));
    chk("tick", 32'(clkout_tick), 32'(fresh));
    chk("running", 32'(running), 32'(q.size() != 0));
    chk("cfg_ready", 32'(cfg_ready), 32'(cfg_valid && q.size() <= 1));
`ifdef CLKOUT_DIV_CTRL_BURST_EN
    chk("burst_done", 32'(burst_done), 32'(b_done));
`endif
    @(posedge clkin);
    model_edge();
    #1;
  endtask
  task automatic offer(input int d);
    bit acc;
    cfg_valid = 1'b1;
    cfg_div = CNT_W'(d);
    last_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      acc = q.size() <= 1;
      step();
      if (acc) break;
    end
    chk("cfg_accept", 32'(last_ready), 32'd1);
    cfg_valid = 1'b0;
  endtask
  task automatic wait_tick();
    for (int i = 0; i < 24 && !fresh; i++) step();
    chk("tick_wait", 32'(clkout_tick), 32'd1);
  endtask
  initial begin
    bit acc;
    #1;
    chk("rst_clkout", 32'(clkout), 32'd0);
    chk("rst_tick", 32'(clkout_tick), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge clkin); @(posedge clkin); #1;
    rst = 1'b0;
    model_reset();
    step();
    run_req = 1'b1;
    repeat (12) step();
    offer(5);
    repeat (12) step();
    offer(0);
    repeat (6) step();
    offer(1);
    repeat (6) step();
    offer(4);
    repeat (6) step();
    wait_tick();
    step();
    run_req = 1'b0;
    repeat (6) step();
    run_req = 1'b1;
    wait_tick();
    step();
    run_req = 1'b0;
    step();
    run_req = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 400; i++) begin
      if (!cfg_valid && $urandom_range(0, 9) == 0) begin
        cfg_valid = 1'b1;
        cfg_div = CNT_W'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      acc = cfg_valid && q.size() <= 1;
      step();
      if (acc) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    run_req = 1'b1;
    for (int i = 0; i < 40 && !clkout; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_clkout", 32'(clkout), 32'd0);
    chk("arst_tick", 32'(clkout_tick), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd0);
    model_reset();
    @(posedge clkin); #1;
    rst = 1'b0;
    repeat (10) step();
`ifdef CLKOUT_DIV_CTRL_BURST_EN
    begin
      int nt, nd;
      run_req = 1'b0;
      repeat (6) step();
      offer(2);
      burst_len = CNT_W'(3);
      run_req = 1'b1;
      nt = 0;
      nd = 0;
      for (int i = 0; i < 14; i++) begin
        step();
        nt += int'(clkout_tick);
        nd += int'(burst_done);
      end
      chk("burst_ticks", 32'(nt), 32'd3);
      chk("burst_done_cnt", 32'(nd), 32'd1);
      chk("burst_hold_low", 32'(clkout), 32'd0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
